serializer: RTL and testbench
=============================

Name: serializer

Overview:
- Parallel-in, serial-out converter. Accepts a DATA_WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Transmit-side counterpart of the team's shift-register deserializer. The default bit order is MSB first, so a deserializer that shifts in at the LSB reconstructs the word unchanged after DATA_WIDTH cycles.
- Supports back-to-back words with no idle bit between them. Sits between a word-oriented producer and a 1-bit link.

Parameters:
- DATA_WIDTH, 16, word width in bits; legal values are 2 and above.
- MSB_FIRST, 1, bit order: 1 sends din[DATA_WIDTH-1] first; 0 sends din[0] first.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_WIDTH  parallel word to send.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block accepts din this cycle.
- dout  output  1  serial data bit.
- dout_valid  output  1  dout carries a valid bit this cycle.
- dout_last  output  1  dout is the final bit of the current word.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: while reset is high at a clock edge, the block clears the state to IDLE and sets shift register=0, bit counter=0, dout=0, dout_valid=0, dout_last=0.
  - din_ready is 0 in any cycle where reset is high.
  - Reset mid-word aborts the word. The remaining bits are dropped, with no partial completion.
- States:
  - IDLE: no word is held.
  - SHIFT: a word is being sent; the bit counter cnt runs 0..DATA_WIDTH-1 and is $clog2(DATA_WIDTH) bits wide.
- din_ready is combinational from registered state only, never from din_valid.
  - din_ready = (state==IDLE) or (state==SHIFT and cnt==DATA_WIDTH-1).
- Accept: a handshake occurs when din_valid & din_ready at a rising edge.
  - At that edge the block loads din into the shift register, sets cnt=0, and sets state=SHIFT.
- Latency: the first bit of an accepted word appears on dout with dout_valid=1 in the cycle immediately after the handshake edge.
  - All outputs are registered.
- Shifting: each cycle in SHIFT presents one bit.
  - MSB_FIRST=1: bits go out in order din[W-1], din[W-2], ..., din[0].
  - MSB_FIRST=0: the order is reversed.
  - cnt increments by 1 per cycle.
- dout_last=1 exactly while cnt==DATA_WIDTH-1 (the final bit); otherwise it is 0.
- End of word, in the cycle where cnt==DATA_WIDTH-1:
  - din_valid=1: the next word is loaded at that edge. Its first bit follows in the next cycle, so dout_valid stays high with no gap.
  - din_valid=0: state goes to IDLE. Next cycle dout_valid=0, dout_last=0, and dout holds 0.
- Word integrity: din and din_valid are ignored outside handshake edges. Changes to din during shifting do not affect the word in flight.
- Producer rule: a producer holding din_valid=1 while din_ready=0 must keep din stable. The block does not check this.
- dout_valid is 1 exactly DATA_WIDTH cycles per accepted word.

Test Plan:
- Basic send, default parameters: reset for 2 cycles, then send din=16'hA5C3 with din_valid for one cycle.
  - Expect dout bits 1010010111000011 on the 16 cycles after the handshake.
  - dout_valid is high for those 16 cycles; dout_last is high only on the 16th; din_ready=0 for the first 15.
- Loopback with the deserializer: feed dout into a deserializer gated by dout_valid and send 16'h1234.
  - On the cycle after dout_last, the deserializer output equals 16'h1234.
- Back-to-back: hold din_valid=1 with 16'hFFFF, then 16'h0001.
  - Expect 32 consecutive dout_valid=1 cycles: 16 ones, then 15 zeros and a one.
  - dout_last pulses on cycles 16 and 32; the second handshake occurs on the cnt==15 edge.
- LSB-first: MSB_FIRST=0, DATA_WIDTH=8, din=8'h01.
  - Expect dout=1 on the first bit and 0 for bits 2–8; dout_last on the 8th bit.
- Reset mid-word: assert reset for 1 cycle after 5 bits of 16'hFFFF.
  - Next cycle dout_valid=0, dout=0, dout_last=0, state=IDLE.
  - din_ready=1 the cycle after reset deasserts, and a new word 16'h8000 sends correctly.
- Idle gap: send 16'h0F0F, hold din_valid=0 for 3 cycles, then send again.
  - dout_valid=0 for exactly 3 cycles between the two 16-cycle bursts.
  - Changing din during the first burst does not change the transmitted bits.

Source files
------------

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module   : serializer
// Purpose  : Parallel-in, serial-out converter. Accepts a DATA_WIDTH-bit word
//            over a valid/ready handshake and emits it one bit per clock,
//            MSB or LSB first. Back-to-back words stream with no idle bit.
// Revision : 1.0 - initial release
// ============================================================================
module serializer #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_last
);

  localparam int                 c_CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [c_CNT_W-1:0]      cnt_q, cnt_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    dout_last_q, dout_last_d;

  logic                    w_on_last;
  logic                    w_accept;
  logic [c_CNT_W-1:0]      w_cnt_inc;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic                    w_out_bit;

  // The bit on the wire is always the outgoing end of the shift register, so
  // dout is a flop output; clearing the register on IDLE forces dout to 0.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_out_bit = shreg_q[DATA_WIDTH-1];
      assign w_shifted = {shreg_q[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit = shreg_q[0];
      assign w_shifted = {1'b0, shreg_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign w_on_last = (state_q == ST_SHIFT) && (cnt_q == c_CNT_LAST);
  assign w_cnt_inc = cnt_q + c_CNT_ONE;

  // Ready depends only on registered state (and reset), never on din_valid,
  // so the producer can safely derive din_valid from din_ready.
  assign din_ready = ~reset & ((state_q == ST_IDLE) | w_on_last);
  assign w_accept  = din_valid & din_ready;

  assign dout       = w_out_bit;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;

  // Next-state: load on handshake, otherwise shift or return to IDLE.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;

    if (w_accept) begin
      state_d      = ST_SHIFT;
      shreg_d      = din;
      cnt_d        = '0;
      dout_valid_d = 1'b1;
      dout_last_d  = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q == c_CNT_LAST) begin
        state_d      = ST_IDLE;
        shreg_d      = '0;
        cnt_d        = '0;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
      end else begin
        shreg_d      = w_shifted;
        cnt_d        = w_cnt_inc;
        dout_valid_d = 1'b1;
        dout_last_d  = (w_cnt_inc == c_CNT_LAST);
      end
    end
  end

  // State and output registers with synchronous reset; reset aborts any word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serializer
// Purpose  : Self-checking bench for serializer. Two instances (16-bit MSB
//            first, 8-bit LSB first) are compared every cycle against a
//            queue-of-bits reference model, plus a loopback deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, MSB-first instance
  logic        rst16, v16, rdy16, do16, dv16, dl16;
  logic [15:0] d16;
  // 8-bit, LSB-first instance
  logic        rst8, v8, rdy8, do8, dv8, dl8;
  logic [7:0]  d8;

  serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) u_dut16 (
    .clk        (clk),
    .reset      (rst16),
    .din        (d16),
    .din_valid  (v16),
    .din_ready  (rdy16),
    .dout       (do16),
    .dout_valid (dv16),
    .dout_last  (dl16)
  );

  serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
    .clk        (clk),
    .reset      (rst8),
    .din        (d8),
    .din_valid  (v8),
    .din_ready  (rdy8),
    .dout       (do8),
    .dout_valid (dv8),
    .dout_last  (dl8)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of bits still to appear on the wire (front is the
  // bit currently shown), and the words expected by the loopback receiver.
  bit          q16[$];
  bit          q8[$];
  logic [15:0] words16[$];
  logic [15:0] deser16 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model at
  // the rising edge using the inputs the bench drove for this cycle.
  task automatic tick(input bit do_check);
    bit          hs16, hs8;
    logic [15:0] w;
    @(negedge clk);
    #1;
    if (do_check) begin
      chk("dout16",  do16,  (q16.size() != 0) ? q16[0] : 1'b0);
      chk("valid16", dv16,  q16.size() != 0);
      chk("last16",  dl16,  q16.size() == 1);
      chk("ready16", rdy16, !rst16 && (q16.size() <= 1));
      chk("dout8",   do8,   (q8.size() != 0) ? q8[0] : 1'b0);
      chk("valid8",  dv8,   q8.size() != 0);
      chk("last8",   dl8,   q8.size() == 1);
      chk("ready8",  rdy8,  !rst8 && (q8.size() <= 1));
      // Loopback receiver: shift in at LSB while valid, compare on the last bit.
      if (dv16 === 1'b1) begin
        deser16 = {deser16[14:0], do16};
        if (dl16 === 1'b1) begin
          if (words16.size() == 0) begin
            chk("loopback_extra", 32'd1, 32'd0);
          end else begin
            w = words16.pop_front();
            chk("loopback16", deser16, w);
          end
        end
      end
    end
    hs16 = v16 && !rst16 && (q16.size() <= 1);
    hs8  = v8  && !rst8  && (q8.size()  <= 1);
    @(posedge clk);
    if (rst16) begin
      q16.delete();
      words16.delete();
    end else begin
      if (q16.size() != 0) void'(q16.pop_front());
      if (hs16) begin
        for (int i = 15; i >= 0; i--) q16.push_back(d16[i]);
        words16.push_back(d16);
      end
    end
    if (rst8) begin
      q8.delete();
    end else begin
      if (q8.size() != 0) void'(q8.pop_front());
      if (hs8) for (int i = 0; i < 8; i++) q8.push_back(d8[i]);
    end
    #1;
  endtask

  task automatic idle16(input int n);
    v16 = 1'b0;
    for (int i = 0; i < n; i++) begin
      d16 = 16'($urandom);
      tick(1'b1);
    end
  endtask

  initial begin
    rst16 = 1'b1; v16 = 1'b0; d16 = '0;
    rst8  = 1'b1; v8  = 1'b0; d8  = '0;

    // Reset for two cycles; outputs are unknown before the first edge.
    tick(1'b0);
    tick(1'b1);
    rst16 = 1'b0; rst8 = 1'b0;
    tick(1'b1);

    // Basic send of A5C3, then loopback of 1234.
    v16 = 1'b1; d16 = 16'hA5C3; tick(1'b1);
    idle16(18);
    v16 = 1'b1; d16 = 16'h1234; tick(1'b1);
    idle16(18);

    // Back-to-back FFFF then 0001 with din_valid held high.
    v16 = 1'b1; d16 = 16'hFFFF; tick(1'b1);
    d16 = 16'h0001;
    for (int i = 0; i < 16; i++) tick(1'b1);
    idle16(18);

    // LSB-first 8-bit word 01.
    v8 = 1'b1; d8 = 8'h01; tick(1'b1);
    v8 = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b1);

    // Reset after five bits of FFFF, then send 8000.
    v16 = 1'b1; d16 = 16'hFFFF; tick(1'b1);
    idle16(5);
    rst16 = 1'b1; tick(1'b1);
    rst16 = 1'b0; tick(1'b1);
    v16 = 1'b1; d16 = 16'h8000; tick(1'b1);
    idle16(18);

    // Idle gap of three cycles between two 0F0F bursts; din churns meanwhile.
    v16 = 1'b1; d16 = 16'h0F0F; tick(1'b1);
    idle16(18);
    v16 = 1'b1; d16 = 16'h0F0F; tick(1'b1);
    idle16(18);

    // Randomized traffic on both instances with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      v16   = ($urandom_range(0, 9) < 7);
      d16   = 16'($urandom);
      rst16 = ($urandom_range(0, 99) == 0);
      v8    = ($urandom_range(0, 9) < 6);
      d8    = 8'($urandom);
      rst8  = ($urandom_range(0, 99) == 0);
      tick(1'b1);
    end
    rst16 = 1'b0; rst8 = 1'b0; v16 = 1'b0; v8 = 1'b0;
    for (int i = 0; i < 20; i++) tick(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
